// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and line-rate constants.
package uart_pkg;

  localparam int unsigned LARGURA_PADRAO  = 16;
  localparam int unsigned CLOKS_POR_BIT   = 5209;
  localparam int unsigned BITS_POR_QUADRO = 18;
  // Roughly twice the time needed to shift one frame out at CLOKS_POR_BIT.
  localparam int unsigned TIMEOUT_PADRAO  = 200000;

  typedef enum logic [2:0] {
    StOcioso,
    StCarrega,
    StDispara,
    StAguardaOcupado,
    StAguardaFim,
    StIntervalo
  } estado_t;

endpackage

// File: rtl/fifo_sincrona.sv
// Circular-buffer FIFO with an occupancy counter; full/empty derive from the counter.
module fifo_sincrona #(
  parameter int unsigned PROFUNDIDADE = 4,
  parameter int unsigned LARGURA      = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              escrita,
  input  logic                              leitura,
  input  logic [LARGURA-1:0]                dado_entrada,
  output logic [LARGURA-1:0]                dado_saida,
  output logic                              cheia,
  output logic                              vazia,
  output logic [$clog2(PROFUNDIDADE):0]     ocupacao
);

  localparam int unsigned PW = $clog2(PROFUNDIDADE);

  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PW:0]        ocupacao_q;
  logic               wr_ok, rd_ok;

  assign cheia      = (ocupacao_q == (PW+1)'(PROFUNDIDADE));
  assign vazia      = (ocupacao_q == '0);
  assign rd_ok      = leitura && !vazia;
  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign wr_ok      = escrita && (!cheia || rd_ok);
  assign dado_saida = mem_q[rd_ptr_q];
  assign ocupacao   = ocupacao_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ocupacao_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (wr_ok && !rd_ok) begin
        ocupacao_q <= ocupacao_q + (PW+1)'(1);
      end else if (rd_ok && !wr_ok) begin
        ocupacao_q <= ocupacao_q - (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= dado_entrada;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Feeds buffered words to the UART transmitter one at a time, with start strobe,
// busy/done handshake, timeout abandonment and sticky overflow flag.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE   = 4,
  parameter int unsigned LARGURA        = LARGURA_PADRAO,
  parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_PADRAO
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [LARGURA-1:0]            palavraEntrada,
  input  logic                          palavraValida,
  output logic                          prontoParaReceber,
  output logic                          haDadosParaTransmitir,
  output logic [LARGURA-1:0]            byteASerTransmitido,
  input  logic                          indicaTransmissao,
  input  logic                          bitsEstaoEnviados,
  output logic [$clog2(PROFUNDIDADE):0] ocupacao,
  output logic                          estouro,
  output logic                          erroTimeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CICLOS + 1);

  estado_t            estado_q, estado_d;
  logic [CW-1:0]      cnt_q;
  logic               intervalo_q;
  logic               estouro_q;
  logic [LARGURA-1:0] byte_q;
  logic [LARGURA-1:0] cabeca;
  logic               cheia, vazia, pop, expirou, aguardando;

  fifo_sincrona #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA      (LARGURA)
  ) u_fifo (
    .clock        (clock),
    .reset_n      (reset_n),
    .escrita      (palavraValida),
    .leitura      (pop),
    .dado_entrada (palavraEntrada),
    .dado_saida   (cabeca),
    .cheia        (cheia),
    .vazia        (vazia),
    .ocupacao     (ocupacao)
  );

  // The in-flight word stays in the FIFO, so a finishing word frees its slot this cycle.
  assign prontoParaReceber   = !cheia || pop;
  assign estouro             = estouro_q;
  assign byteASerTransmitido = byte_q;
  assign aguardando          = (estado_q == StAguardaOcupado) || (estado_q == StAguardaFim);
  assign expirou             = aguardando && (cnt_q == CW'(TIMEOUT_CICLOS - 1));

  always_comb begin
    estado_d              = estado_q;
    pop                   = 1'b0;
    erroTimeout           = 1'b0;
    haDadosParaTransmitir = 1'b0;
    unique case (estado_q)
      StOcioso: if (!vazia) estado_d = StCarrega;
      StCarrega: estado_d = StDispara;
      StDispara: begin
        haDadosParaTransmitir = 1'b1;
        estado_d              = StAguardaOcupado;
      end
      StAguardaOcupado: begin
        if (expirou) begin
          pop         = 1'b1;
          erroTimeout = 1'b1;
          estado_d    = StIntervalo;
        end else if (indicaTransmissao) begin
          estado_d = StAguardaFim;
        end
      end
      StAguardaFim: begin
        // Done wins over a coincident timeout.
        if (bitsEstaoEnviados) begin
          pop      = 1'b1;
          estado_d = StIntervalo;
        end else if (expirou) begin
          pop         = 1'b1;
          erroTimeout = 1'b1;
          estado_d    = StIntervalo;
        end
      end
      StIntervalo: if (intervalo_q) estado_d = StOcioso;
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= StOcioso;
      cnt_q       <= '0;
      intervalo_q <= 1'b0;
      estouro_q   <= 1'b0;
      byte_q      <= '0;
    end else begin
      estado_q    <= estado_d;
      intervalo_q <= (estado_q == StIntervalo);
      if (palavraValida && !prontoParaReceber) estouro_q <= 1'b1;
      if (estado_q == StCarrega) begin
        byte_q <= cabeca;
        cnt_q  <= '0;
      end else if (aguardando) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: single word, burst, overflow, simultaneous
// enqueue/pop, timeout and reset mid-transmission.
module tb_uart_tx_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] palavraEntrada;
  logic        palavraValida;
  logic        prontoParaReceber;
  logic        haDadosParaTransmitir;
  logic [15:0] byteASerTransmitido;
  logic        indicaTransmissao;
  logic        bitsEstaoEnviados;
  logic [2:0]  ocupacao;
  logic        estouro;
  logic        erroTimeout;

  int          checks = 0;
  int          errors = 0;
  int          n_strobes = 0;
  int          n_timeouts = 0;
  int          snap;
  logic [15:0] tx_log[$];

  always #5 clock = ~clock;

  uart_tx_scheduler #(
    .PROFUNDIDADE   (4),
    .LARGURA        (16),
    .TIMEOUT_CICLOS (50)
  ) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .palavraEntrada        (palavraEntrada),
    .palavraValida         (palavraValida),
    .prontoParaReceber     (prontoParaReceber),
    .haDadosParaTransmitir (haDadosParaTransmitir),
    .byteASerTransmitido   (byteASerTransmitido),
    .indicaTransmissao     (indicaTransmissao),
    .bitsEstaoEnviados     (bitsEstaoEnviados),
    .ocupacao              (ocupacao),
    .estouro               (estouro),
    .erroTimeout           (erroTimeout)
  );

  always @(negedge clock) begin
    if (reset_n && haDadosParaTransmitir) begin
      n_strobes++;
      tx_log.push_back(byteASerTransmitido);
    end
    if (reset_n && erroTimeout) n_timeouts++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic enqueue(input logic [15:0] w);
    palavraEntrada = w;
    palavraValida  = 1'b1;
    tick();
    palavraValida  = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!haDadosParaTransmitir && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, haDadosParaTransmitir}, 32'd1);
  endtask

  // Called in the strobe cycle: busy from the next cycle, 2-cycle done pulse later.
  task automatic serve(input logic [15:0] exp, input string tag);
    chk(tag, {16'd0, byteASerTransmitido}, {16'd0, exp});
    tick();
    indicaTransmissao = 1'b1;
    repeat (5) tick();
    bitsEstaoEnviados = 1'b1;
    tick();
    tick();
    bitsEstaoEnviados = 1'b0;
    indicaTransmissao = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n           = 1'b0;
    palavraEntrada    = '0;
    palavraValida     = 1'b0;
    indicaTransmissao = 1'b0;
    bitsEstaoEnviados = 1'b0;
    #12;
    chk("rst_ready",   {31'd0, prontoParaReceber},     32'd1);
    chk("rst_strobe",  {31'd0, haDadosParaTransmitir}, 32'd0);
    chk("rst_byte",    {16'd0, byteASerTransmitido},   32'd0);
    chk("rst_ocup",    {29'd0, ocupacao},              32'd0);
    chk("rst_estouro", {31'd0, estouro},               32'd0);
    chk("rst_erro",    {31'd0, erroTimeout},           32'd0);
    reset_n = 1'b1;
    tick();

    // Single word: strobe two cycles after the word lands.
    enqueue(16'hA55A);
    chk("single_c0_strobe", {31'd0, haDadosParaTransmitir}, 32'd0);
    chk("single_c0_ocup",   {29'd0, ocupacao},              32'd1);
    tick();
    chk("single_c1_strobe", {31'd0, haDadosParaTransmitir}, 32'd0);
    tick();
    chk("single_c2_strobe", {31'd0, haDadosParaTransmitir}, 32'd1);
    serve(16'hA55A, "single_byte");
    tick();
    chk("single_ocup_end", {29'd0, ocupacao}, 32'd0);
    chk("single_strobes",  n_strobes,         32'd1);
    repeat (5) tick();
    chk("single_ocup_stays", {29'd0, ocupacao}, 32'd0);

    // Burst of four fills the FIFO; first word is already in flight.
    enqueue(16'h0001);
    enqueue(16'h0002);
    enqueue(16'h0003);
    enqueue(16'h0004);
    chk("burst_ready",   {31'd0, prontoParaReceber}, 32'd0);
    chk("burst_ocup",    {29'd0, ocupacao},          32'd4);
    chk("burst_estouro", {31'd0, estouro},           32'd0);

    // Overflow: dropped word, sticky flag.
    enqueue(16'hFFFF);
    chk("ovf_estouro", {31'd0, estouro},  32'd1);
    chk("ovf_ocup",    {29'd0, ocupacao}, 32'd4);

    // Finish word 1 while writing word 5 in the pop cycle.
    indicaTransmissao = 1'b1;
    tick();
    tick();
    bitsEstaoEnviados = 1'b1;
    palavraEntrada    = 16'h0005;
    palavraValida     = 1'b1;
    #1;
    chk("simul_ready", {31'd0, prontoParaReceber}, 32'd1);
    tick();
    palavraValida = 1'b0;
    chk("simul_ocup", {29'd0, ocupacao}, 32'd4);
    tick();
    bitsEstaoEnviados = 1'b0;
    indicaTransmissao = 1'b0;
    for (int w = 2; w <= 5; w++) begin
      wait_strobe("burst_strobe");
      serve(w[15:0], "burst_byte");
    end
    repeat (3) tick();
    chk("burst_ocup_end",  {29'd0, ocupacao}, 32'd0);
    chk("burst_log_size",  tx_log.size(),     32'd6);
    chk("log0", {16'd0, tx_log[0]}, 32'hA55A);
    chk("log1", {16'd0, tx_log[1]}, 32'h0001);
    chk("log2", {16'd0, tx_log[2]}, 32'h0002);
    chk("log3", {16'd0, tx_log[3]}, 32'h0003);
    chk("log4", {16'd0, tx_log[4]}, 32'h0004);
    chk("log5", {16'd0, tx_log[5]}, 32'h0005);
    chk("estouro_sticky", {31'd0, estouro}, 32'd1);

    // Timeout: transmitter never goes busy.
    enqueue(16'h1111);
    enqueue(16'h2222);
    wait_strobe("to_strobe");
    chk("to_byte", {16'd0, byteASerTransmitido}, 32'h1111);
    repeat (49) tick();
    chk("to_before", {31'd0, erroTimeout}, 32'd0);
    tick();
    chk("to_pulse",      {31'd0, erroTimeout}, 32'd1);
    chk("to_ocup_pulse", {29'd0, ocupacao},    32'd2);
    tick();
    chk("to_after",      {31'd0, erroTimeout}, 32'd0);
    chk("to_ocup_after", {29'd0, ocupacao},    32'd1);
    wait_strobe("to_next_strobe");
    serve(16'h2222, "to_next_byte");
    repeat (3) tick();
    chk("to_ocup_end", {29'd0, ocupacao}, 32'd0);
    chk("to_count",    n_timeouts,        32'd1);

    // Reset during AguardaFim with three words queued.
    enqueue(16'h00A1);
    enqueue(16'h00A2);
    enqueue(16'h00A3);
    wait_strobe("rm_strobe");
    tick();
    indicaTransmissao = 1'b1;
    tick();
    tick();
    chk("rm_ocup_before", {29'd0, ocupacao}, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_ocup",   {29'd0, ocupacao},              32'd0);
    chk("rm_ready",  {31'd0, prontoParaReceber},     32'd1);
    chk("rm_strobe", {31'd0, haDadosParaTransmitir}, 32'd0);
    indicaTransmissao = 1'b0;
    snap = n_strobes;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) tick();
    chk("rm_no_strobe", n_strobes,         snap);
    chk("rm_ocup_idle", {29'd0, ocupacao}, 32'd0);
    chk("rm_estouro",   {31'd0, estouro},  32'd0);
    enqueue(16'hBEEF);
    tick();
    tick();
    chk("rm_new_strobe", {31'd0, haDadosParaTransmitir}, 32'd1);
    serve(16'hBEEF, "rm_new_byte");
    repeat (3) tick();
    chk("rm_new_ocup", {29'd0, ocupacao}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sits directly upstream of the 16-bit UART transmitter.
- Buffers 16-bit response words from the sensor/command logic in a small FIFO and presents them to the transmitter one at a time.
- Issues a one-cycle start strobe per word, holds the word stable, and waits for the transmitter's busy/done status before releasing the next word.
- Decouples producers from the serial line rate and flags overflow.

Parameters:
- PROFUNDIDADE, 4, FIFO depth in words; power of two, 2..16.
- LARGURA, 16, word width; must equal the transmitter data width.
- TIMEOUT_CICLOS, 200000, max cycles from start strobe to done pulse before the word is abandoned.

Ports:
- clock  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- palavraEntrada  in  LARGURA  word to enqueue
- palavraValida  in  1  producer strobe; word enqueued when palavraValida && prontoParaReceber
- prontoParaReceber  out  1  FIFO not full
- haDadosParaTransmitir  out  1  one-cycle start strobe to transmitter
- byteASerTransmitido  out  LARGURA  word to transmitter, stable from strobe until done
- indicaTransmissao  in  1  transmitter busy
- bitsEstaoEnviados  in  1  transmitter done (may stay high up to 2 consecutive cycles)
- ocupacao  out  clog2(PROFUNDIDADE)+1  words held, including the one in flight
- estouro  out  1  sticky: write attempted while full; cleared only by reset
- erroTimeout  out  1  one-cycle pulse when a word is abandoned

Behaviour:
- Reset (async assert, sync deassert external): all outputs 0 except prontoParaReceber=1; FIFO empty; pointers 0; state OCIOSO.
- FIFO: circular buffer, read/write pointers wrap modulo PROFUNDIDADE. Full/empty are derived from an occupancy counter.
- Simultaneous enqueue and dequeue: both take effect; occupancy is unchanged.
- Write while full: word dropped, estouro set, no pointer change.
- A word leaves the FIFO only when its transmission completes or times out, so ocupacao counts the in-flight word.
- FSM states:
  - OCIOSO: if FIFO not empty → CARREGA.
  - CARREGA: latch head word into byteASerTransmitido register, clear timeout counter → DISPARA.
  - DISPARA: assert haDadosParaTransmitir for exactly this one cycle → AGUARDA_OCUPADO.
  - AGUARDA_OCUPADO: on indicaTransmissao=1 → AGUARDA_FIM.
  - AGUARDA_FIM: on bitsEstaoEnviados=1 → pop head, go to INTERVALO.
  - INTERVALO: held exactly 2 cycles, ignoring bitsEstaoEnviados, so a 2-cycle done pulse is counted once → OCIOSO.
- Timeout:
  - The counter runs in AGUARDA_OCUPADO and AGUARDA_FIM.
  - When the counter reaches TIMEOUT_CICLOS-1 without done: pop the word, pulse erroTimeout, go to INTERVALO.
  - Done arriving in the same cycle as the timeout takes priority: no error pulse.
- Latency: the strobe is asserted 2 cycles after a word enters an empty idle scheduler (enqueue at cycle 0 → CARREGA at 1, strobe at 2).
- byteASerTransmitido changes only in CARREGA.
- Reset mid-transmission: FIFO is flushed and the strobe deasserted immediately. The transmitter is not reset by this block.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (3 bits).
  - LARGURA default 16.
  - CLOKS_POR_BIT 5209 (for deriving the timeout default: 18 bits × 5209 ≈ 94k, doubled ≈ 200k).
- One sub-module: fifo_sincrona (parameterised depth/width, occupancy counter, full/empty).
- The scheduler FSM and timeout counter live in the top module.

Test Plan:
- Single word: enqueue 16'hA55A to an empty scheduler → strobe at cycle+2 with byteASerTransmitido=16'hA55A; model busy from cycle+3 and done (2 cycles) at cycle+100 → ocupacao returns 0 and there is exactly one pop.
- Burst:
  - Enqueue 16'h0001..16'h0004 on 4 consecutive cycles → prontoParaReceber=0 after the 4th.
  - Words are transmitted in order 1,2,3,4 with one strobe each.
  - estouro stays 0.
- Overflow: with FIFO full, a 5th write of 16'hFFFF → estouro=1 (sticky), the word is never transmitted, and the transmitted sequence is unchanged.
- Simultaneous: write a word in the same cycle as the done-pop of a full FIFO → ocupacao stays 4 and the new word is transmitted last.
- Timeout: TIMEOUT_CICLOS=50, transmitter never asserts busy → erroTimeout pulses at 50 cycles after the strobe, the word is dropped, and the next word is strobed.
- Reset mid-operation: assert reset_n=0 during AGUARDA_FIM with 3 words queued → ocupacao=0, prontoParaReceber=1, no further strobes after release until a new enqueue.
